// File: rtl/rpspmc_axis_pkg.sv
// Shared AXIS lane constants, interpolator FSM states and the DAC round/saturate helper.
package rpspmc_axis_pkg;

  localparam int AXIS_DATA_W = 16;
  localparam int AXIS_DAC_W  = 14;
  localparam int AXIS_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } interp_state_t;

  // Drop two LSBs with round-half-up, then clamp into the signed 14-bit DAC range.
  function automatic logic signed [13:0] sat14(input logic signed [15:0] v);
    logic signed [16:0] biased;
    logic signed [16:0] scaled;
    biased = {v[15], v} + 17'sd2;
    scaled = biased >>> 2;
    if (scaled > 17'sd8191) begin
      sat14 = 14'sh1fff;
    end else if (scaled < -17'sd8192) begin
      sat14 = 14'sh2000;
    end else begin
      sat14 = scaled[13:0];
    end
  endfunction

endpackage

// File: rtl/axis_interpolator_interp_lane.sv
// One interpolation channel: segment target, per-point step and scaled accumulator,
// plus the rounded/saturated 16-bit DAC lane derived from the accumulator.
module interp_lane
  import rpspmc_axis_pkg::*;
#(
  parameter int INTERP_LOG2 = 2,
  parameter int DATA_W      = AXIS_DATA_W,
  parameter int SIG_W       = AXIS_DAC_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clear,
  input  logic              load,
  input  logic              from_zero,
  input  logic              advance,
  input  logic              stop,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] lane
);

  localparam int ACC_W = DATA_W + INTERP_LOG2 + 1;

  logic [DATA_W-1:0] target_reg;
  logic [DATA_W:0]   step_reg;
  logic [ACC_W-1:0]  acc_reg;

  logic [DATA_W-1:0] old_val;
  logic [DATA_W:0]   step_new;
  logic [ACC_W-1:0]  old_scaled;
  logic [ACC_W-1:0]  acc_load;
  logic [ACC_W-1:0]  acc_adv;
  logic [DATA_W-1:0] v;
  logic [SIG_W-1:0]  dac;

  // acc holds old*N + k*step, so after N points it lands exactly on new*N.
  always_comb begin
    old_val    = from_zero ? '0 : target_reg;
    step_new   = {sample[DATA_W-1], sample} - {old_val[DATA_W-1], old_val};
    old_scaled = {old_val[DATA_W-1], old_val, {INTERP_LOG2{1'b0}}};
    acc_load   = old_scaled + {{INTERP_LOG2{step_new[DATA_W]}}, step_new};
    acc_adv    = acc_reg + {{INTERP_LOG2{step_reg[DATA_W]}}, step_reg};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      target_reg <= '0;
      step_reg   <= '0;
      acc_reg    <= '0;
    end else if (clear) begin
      target_reg <= '0;
      step_reg   <= '0;
      acc_reg    <= '0;
    end else if (load) begin
      target_reg <= sample;
      step_reg   <= step_new;
      acc_reg    <= acc_load;
    end else begin
      if (advance) begin
        acc_reg <= acc_adv;
      end
      if (stop) begin
        step_reg <= '0;
      end
    end
  end

  assign v    = acc_reg[INTERP_LOG2 +: DATA_W];
  assign dac  = sat14(v);
  assign lane = {{(DATA_W - SIG_W){dac[SIG_W-1]}}, dac};

endmodule

// File: rtl/axis_interpolator.sv
// Two-channel linear interpolator by 2^INTERP_LOG2 feeding the 14-bit DAC; both lanes
// are consumed jointly and packed into one word per aclk, holding the last point on underrun.
module axis_interpolator
  import rpspmc_axis_pkg::*;
#(
  parameter int INTERP_LOG2                        = 2,
  parameter int AXIS_SIGNAL_TDATA_WIDTH            = AXIS_WORD_W,
  parameter int AXIS_SIGNAL_DATA_WIDTH             = AXIS_DATA_W,
  parameter int AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH = AXIS_DAC_W
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               enable,
  input  logic [AXIS_SIGNAL_DATA_WIDTH-1:0]  S_AXIS_S0_tdata,
  input  logic                               S_AXIS_S0_tvalid,
  output logic                               S_AXIS_S0_tready,
  input  logic [AXIS_SIGNAL_DATA_WIDTH-1:0]  S_AXIS_S1_tdata,
  input  logic                               S_AXIS_S1_tvalid,
  output logic                               S_AXIS_S1_tready,
  output logic [AXIS_SIGNAL_TDATA_WIDTH-1:0] M_AXIS_DAC_tdata,
  output logic                               M_AXIS_DAC_tvalid,
  output logic                               underrun
);

  interp_state_t state_reg, state_next;
  logic [INTERP_LOG2-1:0] phase_reg, phase_next;
  logic underrun_reg, underrun_next;
  logic [AXIS_SIGNAL_TDATA_WIDTH-1:0] tdata_reg;
  logic tvalid_reg;

  logic phase_last;
  logic tready_int;
  logic accept;
  logic load, from_zero, advance, stop, clear;
  logic [AXIS_SIGNAL_DATA_WIDTH-1:0] lane0, lane1;

  assign phase_last = &phase_reg;
  // tready is forced low while reset is asserted, not only after the first edge.
  assign tready_int = aresetn && enable &&
                      (state_reg == IDLE || state_reg == HOLD ||
                       (state_reg == RUN && phase_last));
  assign accept     = tready_int && S_AXIS_S0_tvalid && S_AXIS_S1_tvalid;

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    underrun_next = underrun_reg;
    load          = 1'b0;
    from_zero     = 1'b0;
    advance       = 1'b0;
    stop          = 1'b0;
    clear         = 1'b0;
    if (!enable) begin
      state_next    = IDLE;
      phase_next    = '0;
      underrun_next = 1'b0;
      clear         = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            load       = 1'b1;
            from_zero  = 1'b1;
            phase_next = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          if (phase_last) begin
            if (accept) begin
              load       = 1'b1;
              phase_next = '0;
            end else begin
              stop          = 1'b1;
              state_next    = HOLD;
              underrun_next = 1'b1;
            end
          end else begin
            advance    = 1'b1;
            phase_next = phase_reg + INTERP_LOG2'(1);
          end
        end
        HOLD: begin
          if (accept) begin
            load       = 1'b1;
            phase_next = '0;
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      underrun_reg <= underrun_next;
    end
  end

  interp_lane #(
    .INTERP_LOG2 (INTERP_LOG2),
    .DATA_W      (AXIS_SIGNAL_DATA_WIDTH),
    .SIG_W       (AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH)
  ) u_lane0 (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clear     (clear),
    .load      (load),
    .from_zero (from_zero),
    .advance   (advance),
    .stop      (stop),
    .sample    (S_AXIS_S0_tdata),
    .lane      (lane0)
  );

  interp_lane #(
    .INTERP_LOG2 (INTERP_LOG2),
    .DATA_W      (AXIS_SIGNAL_DATA_WIDTH),
    .SIG_W       (AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH)
  ) u_lane1 (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clear     (clear),
    .load      (load),
    .from_zero (from_zero),
    .advance   (advance),
    .stop      (stop),
    .sample    (S_AXIS_S1_tdata),
    .lane      (lane1)
  );

  // Output word reflects the accumulator one edge after it was updated.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
    end else if (enable && state_reg != IDLE) begin
      tdata_reg  <= {lane1, lane0};
      tvalid_reg <= 1'b1;
    end else begin
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
    end
  end

  assign S_AXIS_S0_tready  = tready_int;
  assign S_AXIS_S1_tready  = tready_int;
  assign M_AXIS_DAC_tdata  = tdata_reg;
  assign M_AXIS_DAC_tvalid = tvalid_reg;
  assign underrun          = underrun_reg;

endmodule
